progmem_arbiter: RTL

Two-master arbiter sharing the single-port 64K×32 on-chip program memory. Master 0 is the Nios instruction/data path. Master 1 is a secondary requester, such as a boot loader or DMA. The block grants at most one access per cycle and drives the memory's address, byteenable, chipselect, write and writedata. It also routes the memory's one-cycle-latency read data back to the master that issued the read, using Avalon-MM pipelined semantics.

---
 rtl/progmem_arb_pkg.sv | 16 +
 rtl/progmem_arbiter_if.sv | 32 +++
 rtl/progmem_arb_grant.sv | 44 ++++
 rtl/progmem_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/progmem_arb_pkg.sv
// progmem_arb_pkg: shared widths, master id and request bundle for the program-memory arbiter.
package progmem_arb_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef logic mid_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/progmem_arbiter_if.sv
// progmem_arbiter_if / progmem_mem_if: Avalon-MM bundles for the requesting masters and the
// single-port program memory.
interface progmem_arbiter_if;
    import progmem_arb_pkg::*;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    modport master (output address, byteenable, read, write, writedata,
                    input  waitrequest, readdata, readdatavalid);
    modport slave  (input  address, byteenable, read, write, writedata,
                    output waitrequest, readdata, readdatavalid);
endinterface

interface progmem_mem_if;
    import progmem_arb_pkg::*;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;
    modport master (output address, byteenable, chipselect, write, writedata, clken,
                    input  readdata);
    modport slave  (input  address, byteenable, chipselect, write, writedata, clken,
                    output readdata);
endinterface

// File: rtl/progmem_arb_grant.sv
// progmem_arb_grant: picks one of two requesters; round-robin with a MAX_CONSEC burst cap when
// PROGMEM_ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority to master 0.
module progmem_arb_grant
    import progmem_arb_pkg::*;
#(
    parameter int MAX_CONSEC = 8
) (
`ifdef PROGMEM_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [1:0] i_req,
    output logic       o_gnt,
    output mid_t       o_gnt_id
);
    if (MAX_CONSEC < 1 || MAX_CONSEC > 255) begin : g_bad_max
        $error("MAX_CONSEC must be in 1..255");
    end

    assign o_gnt = |i_req;

`ifdef PROGMEM_ARB_ROUND_ROBIN_EN
    mid_t       r_last_grant;
    logic [7:0] r_consec_cnt;
    logic       w_keep;

    // A zero count only exists out of reset, so the first contention hands off from master 1 to 0.
    assign w_keep   = r_consec_cnt != 8'd0 && r_consec_cnt < 8'(MAX_CONSEC);
    assign o_gnt_id = &i_req ? (w_keep ? r_last_grant : ~r_last_grant) : i_req[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_consec_cnt <= 8'd0;
        end else if (o_gnt) begin
            r_last_grant <= o_gnt_id;
            r_consec_cnt <= (o_gnt_id != r_last_grant) ? 8'd1 :
                            (r_consec_cnt == 8'hff) ? 8'hff : r_consec_cnt + 8'd1;
        end
    end
`else
    assign o_gnt_id = ~i_req[0];
`endif
endmodule

// File: rtl/progmem_arbiter.sv
// progmem_arbiter: two-master Avalon-MM arbiter for the 64Kx32 program memory.
// Define PROGMEM_ARB_ROUND_ROBIN_EN for round-robin with burst cap; default is fixed priority.
module progmem_arbiter
    import progmem_arb_pkg::*;
#(
    parameter int MAX_CONSEC = 8
) (
    input  logic             clk,
    input  logic             reset,
    progmem_arbiter_if.slave m0,
    progmem_arbiter_if.slave m1,
    progmem_mem_if.master    mem
);
    req_t              w_r0, w_r1, w_sel;
    logic [1:0]        w_raw, w_req;
    logic              w_gnt;
    mid_t              w_gnt_id;
    logic              w_rdv0, w_rdv1;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_pend;
    mid_t              r_rd_owner;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    assign w_r0  = '{addr: m0.address, be: m0.byteenable, rd: m0.read, wr: m0.write, wdata: m0.writedata};
    assign w_r1  = '{addr: m1.address, be: m1.byteenable, rd: m1.read, wr: m1.write, wdata: m1.writedata};
    assign w_raw = {w_r1.rd | w_r1.wr, w_r0.rd | w_r0.wr};
    assign w_req = reset ? 2'b00 : w_raw;

    progmem_arb_grant #(.MAX_CONSEC(MAX_CONSEC)) u_grant (
`ifdef PROGMEM_ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .reset    (reset),
`endif
        .i_req    (w_req),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign w_sel = w_gnt_id ? w_r1 : w_r0;

    // Outside reset a requesting master always produces a grant, so only the id decides who waits.
    assign m0.waitrequest = reset | (w_raw[0] & w_gnt_id);
    assign m1.waitrequest = reset | (w_raw[1] & ~w_gnt_id);

    assign mem.address    = w_gnt ? w_sel.addr : r_addr;
    assign mem.byteenable = w_sel.be;
    assign mem.writedata  = w_sel.wdata;
    assign mem.chipselect = w_gnt;
    assign mem.write      = w_gnt & w_sel.wr;
    assign mem.clken      = 1'b1;

    assign w_rdv0           = r_rd_pend & ~r_rd_owner;
    assign w_rdv1           = r_rd_pend & r_rd_owner;
    assign m0.readdatavalid = w_rdv0;
    assign m1.readdatavalid = w_rdv1;
    assign m0.readdata      = w_rdv0 ? mem.readdata : r_rdata0;
    assign m1.readdata      = w_rdv1 ? mem.readdata : r_rdata1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_addr     <= mem.address;
            r_rd_pend  <= w_gnt & w_sel.rd & ~w_sel.wr;
            r_rd_owner <= w_gnt_id;
            r_rdata0   <= m0.readdata;
            r_rdata1   <= m1.readdata;
        end
    end
endmodule
